// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if: requester command/response ports and APB bus signals for apb_master_arb
interface apb_master_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0_valid, req0_write, req0_done, req0_err;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata, req0_rdata;
  logic                  req1_valid, req1_write, req1_done, req1_err;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata, req1_rdata;
  logic                  psel, penable, pwrite, pready;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata, prdata;
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  prdata, pready,
    output req0_done, req0_rdata, req0_err,
    output req1_done, req1_rdata, req1_err,
    output psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output prdata, pready,
    input  req0_done, req0_rdata, req0_err,
    input  req1_done, req1_rdata, req1_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin two-requester APB master with registered outputs.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT cycles without pready.
module apb_master_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input logic clk,
  input logic rstn,
  apb_master_arb_if.master b
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state, state_n;
  logic                  prio, prio_n, gnt, gnt_n;
  logic                  psel, psel_n, penable, pen_n, pwrite, pwrite_n;
  logic [ADDR_WIDTH-1:0] paddr, paddr_n;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_n;
  logic [1:0]            done, done_n;
  logic [DATA_WIDTH-1:0] rdata [2];
  logic [DATA_WIDTH-1:0] rdata_n [2];
  logic                  e0, e1, pick, expire;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master_arb: TIMEOUT must be in 1..255");
  end
`ifdef APB_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  logic [1:0] err, err_n;
  assign expire = ~b.pready && cnt == 8'(TIMEOUT - 1);
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      prio    <= 1'b0;
      gnt     <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      done    <= '0;
      rdata   <= '{default: '0};
`ifdef APB_TIMEOUT_EN
      cnt     <= '0;
      err     <= '0;
`endif
    end else begin
      state   <= state_n;
      prio    <= prio_n;
      gnt     <= gnt_n;
      psel    <= psel_n;
      penable <= pen_n;
      pwrite  <= pwrite_n;
      paddr   <= paddr_n;
      pwdata  <= pwdata_n;
      done    <= done_n;
      rdata   <= rdata_n;
`ifdef APB_TIMEOUT_EN
      cnt     <= cnt_n;
      err     <= err_n;
`endif
    end
  end
  // a requester whose done is high this cycle is still retiring its command, so it is masked
  always_comb begin
    e0       = b.req0_valid & ~done[0];
    e1       = b.req1_valid & ~done[1];
    pick     = (e0 & e1) ? prio : e1;
    state_n  = state;
    prio_n   = prio;
    gnt_n    = gnt;
    psel_n   = psel;
    pen_n    = penable;
    pwrite_n = pwrite;
    paddr_n  = paddr;
    pwdata_n = pwdata;
    done_n   = '0;
    rdata_n  = rdata;
`ifdef APB_TIMEOUT_EN
    cnt_n    = cnt;
    err_n    = '0;
`endif
    case (state)
      IDLE: if (e0 | e1) begin
        state_n  = SETUP;
        gnt_n    = pick;
        prio_n   = ~pick;
        psel_n   = 1'b1;
        pwrite_n = pick ? b.req1_write : b.req0_write;
        paddr_n  = pick ? b.req1_addr  : b.req0_addr;
        pwdata_n = pick ? b.req1_wdata : b.req0_wdata;
      end
      SETUP: begin
        state_n = ACCESS;
        pen_n   = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      ACCESS: if (b.pready | expire) begin
        state_n      = IDLE;
        psel_n       = 1'b0;
        pen_n        = 1'b0;
        done_n[gnt]  = 1'b1;
        rdata_n[gnt] = pwrite ? rdata[gnt] : (expire ? '0 : b.prdata);
`ifdef APB_TIMEOUT_EN
        err_n[gnt]   = expire;
      end else begin
        cnt_n = cnt + 8'd1;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  assign b.psel       = psel;
  assign b.penable    = penable;
  assign b.pwrite     = pwrite;
  assign b.paddr      = paddr;
  assign b.pwdata     = pwdata;
  assign b.req0_done  = done[0];
  assign b.req1_done  = done[1];
  assign b.req0_rdata = rdata[0];
  assign b.req1_rdata = rdata[1];
`ifdef APB_TIMEOUT_EN
  assign b.req0_err   = err[0];
  assign b.req1_err   = err[1];
`else
  assign b.req0_err   = 1'b0;
  assign b.req1_err   = 1'b0;
`endif
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed bench for apb_master_arb with a behavioural APB memory slave.
// Build with APB_TIMEOUT_EN defined to exercise the timeout abort path.
module tb_apb_master_arb;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int passed = 0, total = 0, xfers = 0, d0n = 0, d1n = 0;
  int k0, k1, base0, base1, basex;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] addrq [$];
  apb_master_arb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) b();
  apb_master_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(4)) dut (.clk(clk), .rstn(rstn), .b(b));
  always #5 clk = ~clk;
  assign b.prdata = mem[b.paddr];
  always @(posedge clk) begin
    if (b.req0_done) d0n++;
    if (b.req1_done) d1n++;
    if (rstn && b.psel && b.penable && b.pready) begin
      xfers++;
      addrq.push_back(b.paddr);
      if (b.pwrite) mem[b.paddr] <= b.pwdata;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic req(input bit n, input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
    if (n) begin
      b.req1_valid = v; b.req1_write = w; b.req1_addr = a; b.req1_wdata = d;
    end else begin
      b.req0_valid = v; b.req0_write = w; b.req0_addr = a; b.req0_wdata = d;
    end
  endtask
  task automatic wait_done(input bit n, input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!(n ? b.req1_done : b.req0_done) && k < 20);
    chk(tag, n ? b.req1_done : b.req0_done, 1);
  endtask
  initial begin
    req(0, 0, 0, 8'h00, 8'h00);
    req(1, 0, 0, 8'h00, 8'h00);
    b.pready = 1'b1;
    tick(); tick();
    chk("rst psel", b.psel, 0);
    chk("rst penable", b.penable, 0);
    chk("rst paddr", b.paddr, 0);
    chk("rst pwdata", b.pwdata, 0);
    chk("rst pwrite", b.pwrite, 0);
    chk("rst done0", b.req0_done, 0);
    chk("rst done1", b.req1_done, 0);
    chk("rst rdata0", b.req0_rdata, 0);
    chk("rst err0", b.req0_err, 0);
    rstn = 1'b1;
    // T1: zero-wait write then read back through req0
    req(0, 1, 1, 8'h10, 8'hA5);
    tick();
    chk("t1 psel", b.psel, 1);
    chk("t1 setup penable", b.penable, 0);
    chk("t1 paddr", b.paddr, 8'h10);
    chk("t1 pwdata", b.pwdata, 8'hA5);
    chk("t1 pwrite", b.pwrite, 1);
    tick();
    chk("t1 penable", b.penable, 1);
    chk("t1 no early done", b.req0_done, 0);
    tick();
    chk("t1 done0", b.req0_done, 1);
    chk("t1 psel drop", b.psel, 0);
    chk("t1 done1 quiet", b.req1_done, 0);
    req(0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t1 done0 pulse", b.req0_done, 0);
    chk("t1 mem", mem[8'h10], 8'hA5);
    req(0, 1, 0, 8'h10, 8'h00);
    tick(); tick(); tick();
    chk("t1 rd done0", b.req0_done, 1);
    chk("t1 rdata0", b.req0_rdata, 8'hA5);
    req(0, 0, 0, 8'h00, 8'h00);
    tick();
    chk("t1 rd pulse", b.req0_done, 0);
    chk("t1 rdata0 hold", b.req0_rdata, 8'hA5);
    // T2: both requesters continuously busy after reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    addrq.delete();
    base0 = d0n; base1 = d1n;
    k0 = 0; k1 = 0;
    req(0, 1, 1, 8'h20, 8'h21);
    req(1, 1, 1, 8'h30, 8'h31);
    for (int c = 0; c < 40 && (k0 + k1) < 4; c++) begin
      tick();
      if (b.req0_done) begin k0++; req(0, 1, 1, 8'(8'h20 + k0), 8'(8'h21 + k0)); end
      if (b.req1_done) begin k1++; req(1, 1, 1, 8'(8'h30 + k1), 8'(8'h31 + k1)); end
    end
    req(0, 0, 0, 8'h00, 8'h00);
    req(1, 0, 0, 8'h00, 8'h00);
    tick(); tick();
    chk("t2 transfers", addrq.size(), 4);
    if (addrq.size() == 4) begin
      chk("t2 order0", addrq[0], 8'h20);
      chk("t2 order1", addrq[1], 8'h30);
      chk("t2 order2", addrq[2], 8'h21);
      chk("t2 order3", addrq[3], 8'h31);
    end
    chk("t2 done0 cycles", d0n - base0, 2);
    chk("t2 done1 cycles", d1n - base1, 2);
    // T3: req1 read with three wait states
    b.pready = 1'b0;
    req(1, 1, 0, 8'h30, 8'h00);
    tick();
    chk("t3 setup", {b.psel, b.penable}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3 access sel", {b.psel, b.penable}, 2'b11);
      chk("t3 paddr", b.paddr, 8'h30);
      chk("t3 no done", b.req1_done, 0);
      if (i == 3) b.pready = 1'b1;
    end
    tick();
    chk("t3 done1", b.req1_done, 1);
    chk("t3 rdata1", b.req1_rdata, 8'h31);
    chk("t3 rdata0 hold", b.req0_rdata, 0);
    chk("t3 psel drop", b.psel, 0);
    req(1, 0, 0, 8'h00, 8'h00);
    tick();
    // T4: reset during ACCESS of a req0 write
    base0 = d0n;
    b.pready = 1'b0;
    req(0, 1, 1, 8'h40, 8'h77);
    tick(); tick();
    chk("t4 in access", b.penable, 1);
    rstn = 1'b0;
    #1;
    chk("t4 rst bus", {b.psel, b.penable, b.pwrite}, 0);
    chk("t4 rst paddr", b.paddr, 0);
    chk("t4 rst pwdata", b.pwdata, 0);
    req(0, 0, 0, 8'h00, 8'h00);
    b.pready = 1'b1;
    tick();
    chk("t4 no done0", b.req0_done, 0);
    chk("t4 mem intact", mem[8'h40], 0);
    rstn = 1'b1;
    req(1, 1, 0, 8'h40, 8'h00);
    tick();
    chk("t4 req1 grant", b.psel, 1);
    chk("t4 req1 paddr", b.paddr, 8'h40);
    wait_done(1, "t4 done1");
    chk("t4 rdata1", b.req1_rdata, 0);
    chk("t4 done0 count", d0n - base0, 0);
    req(1, 0, 0, 8'h00, 8'h00);
    tick();
    // T6: five back-to-back req1 writes
    basex = xfers; base1 = d1n;
    addrq.delete();
    for (int i = 0; i < 5; i++) begin
      req(1, 1, 1, 8'(i), 8'(8'hC0 + i));
      wait_done(1, "t6 done1");
    end
    req(1, 0, 0, 8'h00, 8'h00);
    tick(); tick();
    chk("t6 transfers", xfers - basex, 5);
    chk("t6 done pulses", d1n - base1, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < addrq.size()) chk("t6 addr", addrq[i], i);
      chk("t6 mem", mem[i], 8'hC0 + i);
    end
    // T5: pready stuck low on a req0 read
    req(0, 1, 0, 8'h10, 8'h00);
    wait_done(0, "t5 pre done0");
    chk("t5 pre rdata0", b.req0_rdata, 8'hA5);
    req(0, 0, 0, 8'h00, 8'h00);
    tick();
    b.pready = 1'b0;
    req(0, 1, 0, 8'h50, 8'h00);
    tick();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5 waiting", {b.psel, b.penable}, 2'b11);
    end
    tick();
    chk("t5 psel drop", b.psel, 0);
    chk("t5 done0", b.req0_done, 1);
    chk("t5 err0", b.req0_err, 1);
    chk("t5 rdata0", b.req0_rdata, 0);
`else
    repeat (100) tick();
    chk("t5 still access", {b.psel, b.penable}, 2'b11);
    chk("t5 err0", b.req0_err, 0);
    chk("t5 no done0", b.req0_done, 0);
`endif
    req(0, 0, 0, 8'h00, 8'h00);
    rstn = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
